// File: rtl/jamma_pkg.sv
// jamma_pkg
// Shared definitions for the JAMMA input scanner:
//   - scan_state_t : 2-bit scan FSM encoding (SEL_A=0, SAMP_A=1, SEL_B=2, SAMP_B=3)
//   - JOY_IDLE     : released-button level of an 8-bit active-low player word
//   - COIN_IDLE    : released level of the two active-low coin switches
//   - mergeLocal   : folds the local DB9 joystick into the player A word
`timescale 1ns/1ps

package jamma_pkg;

    typedef enum logic [1:0] {
        SEL_A  = 2'd0,
        SAMP_A = 2'd1,
        SEL_B  = 2'd2,
        SAMP_B = 2'd3
    } scan_state_t;

    localparam logic [7:0] JOY_IDLE  = 8'hFF;
    localparam logic [1:0] COIN_IDLE = 2'b11;

    // Active-low buses combine with AND: a press on either source shows up.
    // The two top bits have no local counterpart and are left released.
    function automatic logic [7:0] mergeLocal(input logic [7:0] bus,
                                              input logic [5:0] localJoy);
        return bus & {2'b11, localJoy};
    endfunction

endpackage

// File: rtl/jamma_debounce_bit.sv
// jamma_debounce_bit
// One debounced output bit. The held level only changes after SAMPLES
// consecutive sample strobes disagree with it; any agreeing sample clears
// the run counter.
// Ports:
//   pclk        in   clock, rising edge
//   reset       in   synchronous active-high reset (level -> 1, count -> 0)
//   i_sampleEn  in   one-cycle strobe marking a valid scan sample
//   i_sample    in   synchronized raw sample value
//   o_level     out  debounced level
`timescale 1ns/1ps

module jamma_debounce_bit #(
    parameter int SAMPLES = 3
) (
    input  logic pclk,
    input  logic reset,
    input  logic i_sampleEn,
    input  logic i_sample,
    output logic o_level
);

    localparam int CNT_W = $clog2(SAMPLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES - 1);

    logic             r_level;
    logic [CNT_W-1:0] r_runCnt;
    logic             w_differs;

    assign w_differs = (i_sample != r_level);

    // The counter holds how many consecutive disagreeing samples have been
    // seen so far; the SAMPLES-th one flips the level and restarts the run.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_level  <= 1'b1;
            r_runCnt <= '0;
        end else if (i_sampleEn) begin
            if (!w_differs) begin
                r_runCnt <= '0;
            end else if (r_runCnt == CNT_LAST) begin
                r_level  <= i_sample;
                r_runCnt <= '0;
            end else begin
                r_runCnt <= r_runCnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/jamma_input_scanner.sv
// jamma_input_scanner
// Scans a multiplexed JAMMA joystick bus for two players by toggling
// jselect, letting the bus settle, then sampling. Player A is merged with a
// local DB9 joystick; coins are sampled once per full scan. Optional
// per-bit debouncing is enabled by defining JAMMA_DEBOUNCE_EN.
// Ports:
//   pclk            in   clock, rising edge
//   reset           in   synchronous active-high reset
//   jjoy[7:0]       in   JAMMA joystick/button bus, active-low, async
//   jcoin[1:0]      in   coin switches, active-low, async
//   joystick_local  in   local DB9 joystick [5:0], active-low, async
//   jselect         out  mux select to the JAMMA board (0 = A, 1 = B)
//   joy_a[7:0]      out  player A buttons, active-low, merged with local
//   joy_b[7:0]      out  player B buttons, active-low
//   coin[1:0]       out  coin levels, active-low
//   coin_pulse[1:0] out  one-cycle pulse per coin press
//   scan_done       out  one-cycle pulse when a full A+B scan completes
`timescale 1ns/1ps

module jamma_input_scanner
    import jamma_pkg::*;
#(
    parameter int SETTLE_CYCLES    = 4,
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [7:0] jjoy,
    input  logic [1:0] jcoin,
    input  logic [5:0] joystick_local,
    output logic       jselect,
    output logic [7:0] joy_a,
    output logic [7:0] joy_b,
    output logic [1:0] coin,
    output logic [1:0] coin_pulse,
    output logic       scan_done
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 ||
        DEBOUNCE_SAMPLES < 2 || DEBOUNCE_SAMPLES > 7) begin : g_paramCheck
        $error("jamma_input_scanner: parameter out of legal range");
    end

    logic [7:0]       r_jjoyMeta, r_jjoySync;
    logic [1:0]       r_coinMeta, r_coinSync;
    logic [5:0]       r_localMeta, r_localSync;
    scan_state_t      r_state, w_nextState;
    logic [CNT_W-1:0] r_settleCnt;
    logic             r_scanDone;
    logic [1:0]       r_coinPrev;
    logic [7:0]       w_rawA;
    logic             w_sampA, w_sampB;

    // Two-flop synchronizers; reset to the released (all-ones) level so no
    // phantom press is seen while the pipeline refills.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_jjoyMeta  <= JOY_IDLE;
            r_jjoySync  <= JOY_IDLE;
            r_coinMeta  <= COIN_IDLE;
            r_coinSync  <= COIN_IDLE;
            r_localMeta <= '1;
            r_localSync <= '1;
        end else begin
            r_jjoyMeta  <= jjoy;
            r_jjoySync  <= r_jjoyMeta;
            r_coinMeta  <= jcoin;
            r_coinSync  <= r_coinMeta;
            r_localMeta <= joystick_local;
            r_localSync <= r_localMeta;
        end
    end

    // Scan state register and settle counter. The counter only runs in the
    // SEL states and is zero in every SAMP state, so each SEL entry starts
    // from a fresh count.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state     <= SEL_A;
            r_settleCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if ((r_state == SEL_A || r_state == SEL_B) && r_settleCnt != SETTLE_LAST) begin
                r_settleCnt <= r_settleCnt + 1'b1;
            end else begin
                r_settleCnt <= '0;
            end
        end
    end

    // Next-state and select decode. jselect depends on state only, so it
    // stays stable through the SAMP cycle that follows each SEL phase.
    always_comb begin
        w_nextState = r_state;
        jselect     = 1'b0;
        case (r_state)
            SEL_A: begin
                if (r_settleCnt == SETTLE_LAST) begin
                    w_nextState = SAMP_A;
                end
            end
            SAMP_A: begin
                w_nextState = SEL_B;
            end
            SEL_B: begin
                jselect = 1'b1;
                if (r_settleCnt == SETTLE_LAST) begin
                    w_nextState = SAMP_B;
                end
            end
            SAMP_B: begin
                jselect     = 1'b1;
                w_nextState = SEL_A;
            end
            default: begin
                w_nextState = SEL_A;
            end
        endcase
    end

    assign w_sampA = (r_state == SAMP_A);
    assign w_sampB = (r_state == SAMP_B);
    assign w_rawA  = mergeLocal(r_jjoySync, r_localSync);

`ifdef JAMMA_DEBOUNCE_EN
    // One filter per output bit: 8 for A, 8 for B, 2 for the coins.
    for (genvar i = 0; i < 8; i++) begin : g_debA
        jamma_debounce_bit #(.SAMPLES(DEBOUNCE_SAMPLES)) u_bit (
            .pclk       (pclk),
            .reset      (reset),
            .i_sampleEn (w_sampA),
            .i_sample   (w_rawA[i]),
            .o_level    (joy_a[i])
        );
    end
    for (genvar i = 0; i < 8; i++) begin : g_debB
        jamma_debounce_bit #(.SAMPLES(DEBOUNCE_SAMPLES)) u_bit (
            .pclk       (pclk),
            .reset      (reset),
            .i_sampleEn (w_sampB),
            .i_sample   (r_jjoySync[i]),
            .o_level    (joy_b[i])
        );
    end
    for (genvar i = 0; i < 2; i++) begin : g_debCoin
        jamma_debounce_bit #(.SAMPLES(DEBOUNCE_SAMPLES)) u_bit (
            .pclk       (pclk),
            .reset      (reset),
            .i_sampleEn (w_sampB),
            .i_sample   (r_coinSync[i]),
            .o_level    (coin[i])
        );
    end
`else
    logic [7:0] r_joyA, r_joyB;
    logic [1:0] r_coin;

    // Without filtering the outputs simply latch the raw sample taken in
    // the matching SAMP state.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_joyA <= JOY_IDLE;
            r_joyB <= JOY_IDLE;
            r_coin <= COIN_IDLE;
        end else begin
            if (w_sampA) begin
                r_joyA <= w_rawA;
            end
            if (w_sampB) begin
                r_joyB <= r_jjoySync;
                r_coin <= r_coinSync;
            end
        end
    end

    assign joy_a = r_joyA;
    assign joy_b = r_joyB;
    assign coin  = r_coin;
`endif

    // scan_done follows SAMP_B, landing in the same cycle joy_b and coin
    // update. r_coinPrev trails coin by one cycle so a falling edge of
    // coin yields exactly a one-cycle pulse, coincident with the update.
    always_ff @(posedge pclk) begin
        if (reset) begin
            r_scanDone <= 1'b0;
            r_coinPrev <= COIN_IDLE;
        end else begin
            r_scanDone <= w_sampB;
            r_coinPrev <= coin;
        end
    end

    assign scan_done  = r_scanDone;
    assign coin_pulse = r_coinPrev & ~coin;

endmodule

// File: doc/jamma_input_scanner.md
JAMMA_INPUT_SCANNER -- requirements
Module: jamma_input_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning cycles JSELECT is held before sampling (legal 1..15).
REQ-002 SHALL have parameter DEBOUNCE_SAMPLES, default 3, meaning consecutive equal scan samples required to accept a bit change (legal 2..7).
REQ-003 SHALL have port pclk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port jjoy  input  8  multiplexed JAMMA joystick/button bus, active-low, asynchronous.
REQ-006 SHALL have port jcoin  input  2  coin switches, active-low, asynchronous.
REQ-007 SHALL have port joystick_local  input  6  local DB9 joystick, active-low, asynchronous.
REQ-008 SHALL have port jselect  output  1  mux select to JAMMA board: 0 = player A, 1 = player B.
REQ-009 SHALL have port joy_a  output  8  player A buttons, active-low, merged with local joystick.
REQ-010 SHALL have port joy_b  output  8  player B buttons, active-low.
REQ-011 SHALL have port coin  output  2  debounced coin levels, active-low.
REQ-012 SHALL have port coin_pulse  output  2  one-cycle pulse per debounced coin press.
REQ-013 SHALL have port scan_done  output  1  one-cycle pulse when a full A+B scan completes.

Function
REQ-014 SHALL pass jjoy, jcoin, joystick_local through two-flop synchronizers before any use.
REQ-015 SHALL run FSM SEL_A -> SAMP_A -> SEL_B -> SAMP_B -> SEL_A continuously.
REQ-016 SEL_A/SEL_B SHALL drive jselect 0/1 and hold SETTLE_CYCLES cycles via a settle counter; SAMP_x lasts exactly 1 cycle with jselect unchanged.
REQ-017 Full scan period SHALL be 2*(SETTLE_CYCLES+1) cycles (10 at defaults).
REQ-018 In SAMP_A SHALL capture raw_a = sync_jjoy AND {2'b11, sync_local}; in SAMP_B raw_b = sync_jjoy.
REQ-019 Coins SHALL be sampled once per scan, in SAMP_B.
REQ-020 Output registers SHALL update the cycle after the corresponding SAMP state.
REQ-021 coin_pulse[i] SHALL assert for one cycle on the cycle coin[i] transitions 1->0; never on 0->1.
REQ-022 scan_done SHALL assert the cycle after SAMP_B, coincident with joy_b/coin update.
REQ-023 Both coins pressed in the same scan SHALL produce both coin_pulse bits in the same cycle.
REQ-024 Settle counter SHALL be width ceil(log2(SETTLE_CYCLES+1)) and reload on every SEL entry; no wrap beyond SETTLE_CYCLES-1.

Reset
REQ-025 While reset high: FSM = SEL_A, settle counter 0, jselect 0, joy_a = joy_b = 8'hFF, coin = 2'b11, coin_pulse = 0, scan_done = 0, synchronizers and debounce state set to all-ones/zero-count.
REQ-026 Reset asserted mid-scan SHALL abort immediately; first SAMP_A after release occurs SETTLE_CYCLES cycles after reset deassertion.

Configuration
REQ-027 Macro JAMMA_DEBOUNCE_EN defined: each bit of joy_a, joy_b, coin SHALL change only after DEBOUNCE_SAMPLES consecutive scan samples differ from current output; any agreeing sample resets that bit's counter.
REQ-028 Macro undefined: outputs SHALL take raw samples directly (latency per REQ-020); debounce counters not instantiated; DEBOUNCE_SAMPLES ignored.

Structure
REQ-029 Shared package jamma_pkg SHALL hold FSM state encoding (2-bit: SEL_A=0, SAMP_A=1, SEL_B=2, SAMP_B=3) and constant JOY_IDLE = 8'hFF.
REQ-030 Per-bit debounce SHALL be a sub-module jamma_debounce_bit (counter + held level), instantiated 18 times under JAMMA_DEBOUNCE_EN.

Verification
REQ-031 Reset released, all inputs 1 -> jselect toggles every 5 cycles, scan_done every 10 cycles, joy_a/joy_b stay 8'hFF.
REQ-032 No debounce: jjoy = 8'hFE only while jselect=0 -> joy_a = 8'hFE, joy_b = 8'hFF after next scan.
REQ-033 joystick_local = 6'b111101, jjoy = 8'hFF -> joy_a = 8'hFD.
REQ-034 Debounce on: jcoin[0] low for 2 scans then high -> no coin_pulse; low for 3 scans -> exactly one coin_pulse[0].
REQ-035 Both jcoin low same scan -> coin_pulse = 2'b11 for one cycle, coincident with scan_done.
REQ-036 Reset asserted during SEL_B with joy_b = 8'h7F -> next cycle joy_b = 8'hFF, jselect = 0.
